uart_xcvr: RTL and testbench
============================

UART_XCVR -- requirements
Module: uart_xcvr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter PARITY_MODE, default 1, meaning 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits transmitted, legal 1..2.
REQ-004 SHALL have parameter CLOCKS_PER_BIT, default 8, clk cycles per bit, even, legal >= 4.
REQ-005 SHALL have parameter NUMBER_OF_RX_SYNCHRONIZERS, default 3, number of serial_in synchroniser flops, legal >= 2.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-008 SHALL have port enable, input, 1 bit: Tx start request.
REQ-009 SHALL have port i_data, input, DATA_WIDTH bits: Tx payload.
REQ-010 SHALL have port o_busy, output, 1 bit: Tx frame in progress.
REQ-011 SHALL have port serial_out, output, 1 bit: Tx line, idle high.
REQ-012 SHALL have port serial_in, input, 1 bit: asynchronous Rx line, idle high.
REQ-013 SHALL have port received_data, output, DATA_WIDTH bits: last received payload.
REQ-014 SHALL have port data_is_valid, output, 1 bit: one-cycle pulse, good frame received.
REQ-015 SHALL have port rx_error, output, 1 bit: one-cycle pulse, parity mismatch.
REQ-016 SHALL have port framing_error, output, 1 bit: one-cycle pulse, stop bit sampled low.

Function
REQ-017 Tx SHALL capture i_data when enable=1 and o_busy=0, and SHALL ignore enable while o_busy=1.
REQ-018 o_busy SHALL rise the cycle after capture and fall after the last stop-bit cycle, allowing enable in that same cycle to start the next frame back-to-back.
REQ-019 Tx frame SHALL be: start 0, data LSB first, parity bit if PARITY_MODE!=0 (even: ^data; odd: ~^data), then STOP_BITS ones, each bit CLOCKS_PER_BIT cycles.
REQ-020 Frame length SHALL be FRAME_BITS = 1 + DATA_WIDTH + (PARITY_MODE!=0) + STOP_BITS.
REQ-021 Tx SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY_MODE=0.
REQ-022 Rx SHALL sample serial_in through NUMBER_OF_RX_SYNCHRONIZERS flops initialised high and detect a start on a 1->0 synchronised edge in IDLE.
REQ-023 Rx SHALL sample each bit at cycle CLOCKS_PER_BIT/2 of the bit.
REQ-024 Rx SHALL return to IDLE without any output pulse if the start bit samples high (glitch rejection).
REQ-025 Rx SHALL use states IDLE, START, DATA, PARITY, STOP and check only the first stop bit.
REQ-026 Rx SHALL return to IDLE immediately after the stop sample, so a new start edge is accepted within the second stop or idle time.
REQ-027 On the stop sample, the next cycle SHALL pulse exactly one of: data_is_valid (stop=1, parity OK), rx_error (parity bad), or framing_error (stop=0; wins over parity).
REQ-028 received_data SHALL update with the pulse and hold until the next pulse; it SHALL also update on error pulses.
REQ-029 Bit and cycle counters SHALL be sized with $clog2 of their maximum plus one and SHALL NOT wrap inside a frame.

Reset
REQ-030 While reset=0 at a clk edge, outputs SHALL be: serial_out=1, o_busy=0, received_data=0, data_is_valid=0, rx_error=0, framing_error=0.
REQ-031 While reset=0 at a clk edge, both FSMs SHALL be IDLE and synchronisers all 1.
REQ-032 Reset mid-frame SHALL abort both directions with no pulses; the first capture SHALL be possible the cycle after reset=1.

Structure
REQ-033 Package uart_pkg SHALL hold the parity-mode constants, the Tx/Rx state encodings, and a FRAME_BITS function.
REQ-034 Sub-module uart_rx_sync (parametrised flop chain, reset-high) SHALL be the only sub-module; Tx and Rx FSMs SHALL reside in uart_xcvr.

Verification
REQ-035 Defaults, enable with i_data=8'hA5 -> serial_out 0,1,0,1,0,0,1,0,1, parity 0, stop 1; o_busy high 88 cycles.
REQ-036 Loopback (serial_in=serial_out), i_data=8'h3C -> single data_is_valid with received_data=8'h3C, rx_error=framing_error=0.
REQ-037 PARITY_MODE=2, i_data=8'h01 -> parity bit 0; Rx with parity bit flipped to 1 -> rx_error pulse, no data_is_valid.
REQ-038 Rx frame with stop bit driven 0 -> framing_error pulse only; next valid frame 8'h55 -> data_is_valid, received_data=8'h55.
REQ-039 serial_in low for 2 cycles then high -> no pulse; Rx back in IDLE.
REQ-040 reset=0 at cycle 30 of a Tx frame -> next cycle serial_out=1, o_busy=0; enable after release -> full frame sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, Tx/Rx state encodings and frame length helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
    TxParity,
    TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxParity,
    RxStop
  } rx_state_e;

  // Total bits on the wire for one frame, start and stop bits included.
  function automatic int unsigned frame_bits(input int unsigned data_width,
                                             input int unsigned parity_mode,
                                             input int unsigned stop_bits);
    return 1 + data_width + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Flop chain bringing the asynchronous Rx line into the clk domain; resets to line-idle (high).
module uart_rx_sync #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      chain_q <= '1;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART: framed transmitter and mid-bit sampling receiver with parity/framing checks.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH                 = 8,
  parameter int unsigned PARITY_MODE                = PARITY_EVEN,
  parameter int unsigned STOP_BITS                  = 1,
  parameter int unsigned CLOCKS_PER_BIT             = 8,
  parameter int unsigned NUMBER_OF_RX_SYNCHRONIZERS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_busy,
  output logic                  serial_out,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] received_data,
  output logic                  data_is_valid,
  output logic                  rx_error,
  output logic                  framing_error
);

  localparam int unsigned CycCntW = $clog2(CLOCKS_PER_BIT);
  localparam int unsigned BitCntW = $clog2(DATA_WIDTH);

  localparam logic [CycCntW-1:0] CycLast  = CycCntW'(CLOCKS_PER_BIT - 1);
  localparam logic [CycCntW-1:0] CycHalf  = CycCntW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [BitCntW-1:0] DataLast = BitCntW'(DATA_WIDTH - 1);
  localparam logic [BitCntW-1:0] StopLast = BitCntW'(STOP_BITS - 1);
  localparam bit                 HasParity = (PARITY_MODE != PARITY_NONE);

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_e             tx_state_q, tx_state_d;
  logic [CycCntW-1:0]    tx_cyc_q, tx_cyc_d;
  logic [BitCntW-1:0]    tx_bit_q, tx_bit_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_bit_done;
  logic                  tx_parity;

  assign tx_bit_done = (tx_cyc_q == CycLast);
  assign tx_parity   = (PARITY_MODE == PARITY_ODD) ? ~^tx_data_q : ^tx_data_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cyc_d   = tx_cyc_q;
    tx_bit_d   = tx_bit_q;
    tx_data_d  = tx_data_q;

    if (tx_state_q != TxIdle) begin
      tx_cyc_d = tx_bit_done ? '0 : tx_cyc_q + 1'b1;
    end

    unique case (tx_state_q)
      TxIdle: begin
        if (enable) begin
          tx_data_d  = i_data;
          tx_state_d = TxStart;
          tx_cyc_d   = '0;
          tx_bit_d   = '0;
        end
      end
      TxStart: begin
        if (tx_bit_done) begin
          tx_state_d = TxData;
        end
      end
      TxData: begin
        if (tx_bit_done) begin
          if (tx_bit_q == DataLast) begin
            tx_bit_d   = '0;
            tx_state_d = HasParity ? TxParity : TxStop;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      TxParity: begin
        if (tx_bit_done) begin
          tx_state_d = TxStop;
        end
      end
      TxStop: begin
        if (tx_bit_done) begin
          if (tx_bit_q == StopLast) begin
            tx_bit_d   = '0;
            tx_state_d = TxIdle;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q <= TxIdle;
      tx_cyc_q   <= '0;
      tx_bit_q   <= '0;
      tx_data_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cyc_q   <= tx_cyc_d;
      tx_bit_q   <= tx_bit_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    serial_out = 1'b1;
    unique case (tx_state_q)
      TxStart:  serial_out = 1'b0;
      TxData:   serial_out = tx_data_q[tx_bit_q];
      TxParity: serial_out = tx_parity;
      default:  serial_out = 1'b1;
    endcase
  end

  assign o_busy = (tx_state_q != TxIdle);

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic                  rx_sync;
  logic                  rx_prev_q;
  rx_state_e             rx_state_q, rx_state_d;
  logic [CycCntW-1:0]    rx_cyc_q, rx_cyc_d;
  logic [BitCntW-1:0]    rx_bit_q, rx_bit_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                  rx_par_q, rx_par_d;
  logic                  rx_par_ok;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_perr_q, rx_perr_d;
  logic                  rx_ferr_q, rx_ferr_d;

  uart_rx_sync #(
    .STAGES (NUMBER_OF_RX_SYNCHRONIZERS)
  ) u_rx_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (serial_in),
    .sync_o  (rx_sync)
  );

  always_comb begin
    rx_par_ok = 1'b1;
    if (PARITY_MODE == PARITY_EVEN) begin
      rx_par_ok = ~^{rx_shift_q, rx_par_q};
    end else if (PARITY_MODE == PARITY_ODD) begin
      rx_par_ok = ^{rx_shift_q, rx_par_q};
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cyc_d   = rx_cyc_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_perr_d  = 1'b0;
    rx_ferr_d  = 1'b0;

    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync) begin
          rx_state_d = RxStart;
          rx_cyc_d   = '0;
          rx_bit_d   = '0;
        end
      end
      RxStart: begin
        // Half a bit in: a high line here was a glitch, not a start bit.
        if (rx_cyc_q == CycHalf) begin
          rx_cyc_d   = '0;
          rx_state_d = rx_sync ? RxIdle : RxData;
        end else begin
          rx_cyc_d = rx_cyc_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cyc_q == CycLast) begin
          rx_cyc_d   = '0;
          rx_shift_d = {rx_sync, rx_shift_q[DATA_WIDTH-1:1]};
          if (rx_bit_q == DataLast) begin
            rx_bit_d   = '0;
            rx_state_d = HasParity ? RxParity : RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cyc_d = rx_cyc_q + 1'b1;
        end
      end
      RxParity: begin
        if (rx_cyc_q == CycLast) begin
          rx_cyc_d   = '0;
          rx_par_d   = rx_sync;
          rx_state_d = RxStop;
        end else begin
          rx_cyc_d = rx_cyc_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cyc_q == CycLast) begin
          rx_cyc_d   = '0;
          rx_state_d = RxIdle;
          rx_data_d  = rx_shift_q;
          if (!rx_sync) begin
            rx_ferr_d = 1'b1;
          end else if (!rx_par_ok) begin
            rx_perr_d = 1'b1;
          end else begin
            rx_valid_d = 1'b1;
          end
        end else begin
          rx_cyc_d = rx_cyc_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cyc_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_prev_q  <= rx_sync;
      rx_state_q <= rx_state_d;
      rx_cyc_q   <= rx_cyc_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign received_data = rx_data_q;
  assign data_is_valid = rx_valid_q;
  assign rx_error      = rx_perr_q;
  assign framing_error = rx_ferr_q;

endmodule

// File: tb/tb_uart_xcvr.sv
// Bench for uart_xcvr: an even-parity (default) and an odd-parity instance against a frame model.
module tb_uart_xcvr;

  localparam int CPB   = 8;
  localparam int NBITS = 11;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       rx_drive = 1'b1;
  logic       loopback = 1'b0;

  logic       busy_a, so_a, si_a, dv_a, re_a, fe_a;
  logic [7:0] rd_a;
  logic       busy_b, so_b, si_b, dv_b, re_b, fe_b;
  logic [7:0] rd_b;

  int errors = 0;
  int checks = 0;

  // Pulse tallies per instance: index 0 = even parity, 1 = odd parity.
  int         nv[2] = '{0, 0};
  int         np[2] = '{0, 0};
  int         nf[2] = '{0, 0};
  logic [7:0] last_rx[2];

  always #5 clk = ~clk;

  assign si_a = loopback ? so_a : rx_drive;
  assign si_b = loopback ? so_b : rx_drive;

  uart_xcvr dut_a (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .i_data        (i_data),
    .o_busy        (busy_a),
    .serial_out    (so_a),
    .serial_in     (si_a),
    .received_data (rd_a),
    .data_is_valid (dv_a),
    .rx_error      (re_a),
    .framing_error (fe_a)
  );

  uart_xcvr #(
    .PARITY_MODE (2)
  ) dut_b (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .i_data        (i_data),
    .o_busy        (busy_b),
    .serial_out    (so_b),
    .serial_in     (si_b),
    .received_data (rd_b),
    .data_is_valid (dv_b),
    .rx_error      (re_b),
    .framing_error (fe_b)
  );

  always @(negedge clk) begin
    if (dv_a) begin nv[0]++; last_rx[0] = rd_a; end
    if (re_a) begin np[0]++; last_rx[0] = rd_a; end
    if (fe_a) begin nf[0]++; last_rx[0] = rd_a; end
    if (dv_b) begin nv[1]++; last_rx[1] = rd_b; end
    if (re_b) begin np[1]++; last_rx[1] = rd_b; end
    if (fe_b) begin nf[1]++; last_rx[1] = rd_b; end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level of bit idx in a frame; mode 1 even, 2 odd.
  function automatic logic model_bit(input int mode, input logic [7:0] d, input int idx);
    int ones;
    ones = $countones(d);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9) return (mode == 2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return 1'b1;
  endfunction

  // 0 = good frame, 1 = parity error, 2 = framing error.
  function automatic int model_outcome(input int mode, input logic [7:0] d, input logic p,
                                       input logic stop);
    int ones;
    if (!stop) return 2;
    ones = $countones(d) + int'(p);
    if (mode == 1) return ((ones % 2) == 0) ? 0 : 1;
    return ((ones % 2) == 1) ? 0 : 1;
  endfunction

  // Called in the first cycle after capture; ends in the first idle cycle.
  task automatic check_tx_frame(input int k, input logic [7:0] d, input string name);
    logic so, bz, exp;
    for (int c = 0; c < NBITS * CPB; c++) begin
      so  = (k == 0) ? so_a : so_b;
      bz  = (k == 0) ? busy_a : busy_b;
      exp = model_bit(k + 1, d, c / CPB);
      checks++;
      if (so !== exp || bz !== 1'b1) begin
        errors++;
        $display("FAIL %s cycle %0d: serial_out=%b o_busy=%b, required serial_out=%b o_busy=1",
                 name, c, so, bz, exp);
      end
      tick();
    end
    so = (k == 0) ? so_a : so_b;
    bz = (k == 0) ? busy_a : busy_b;
    checks++;
    if (so !== 1'b1 || bz !== 1'b0) begin
      errors++;
      $display("FAIL %s end: serial_out=%b o_busy=%b, required 1/0", name, so, bz);
    end
  endtask

  task automatic tx_send(input int k, input logic [7:0] d, input string name);
    i_data = d;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    i_data = 8'($urandom);
    check_tx_frame(k, d, name);
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic p, input logic stop, input int gap);
    logic [10:0] bits;
    bits = {stop, p, d, 1'b0};
    for (int i = 0; i < NBITS; i++) begin
      rx_drive = bits[i];
      repeat (CPB) tick();
    end
    rx_drive = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic check_counts(input int k, input int dv, input int dp, input int df,
                              input int bv, input int bp, input int bf, input string name);
    checks++;
    if (nv[k] - bv !== dv || np[k] - bp !== dp || nf[k] - bf !== df) begin
      errors++;
      $display("FAIL %s dut%0d: valid/parity/framing pulses=%0d/%0d/%0d, required %0d/%0d/%0d",
               name, k, nv[k] - bv, np[k] - bp, nf[k] - bf, dv, dp, df);
    end
  endtask

  // Drives one frame onto the shared Rx line and checks both instances against the model.
  task automatic rx_frame_check(input logic [7:0] d, input logic p, input logic stop,
                                input string name);
    int bv[2], bp[2], bf[2];
    int oc;
    logic [7:0] rd;
    for (int k = 0; k < 2; k++) begin bv[k] = nv[k]; bp[k] = np[k]; bf[k] = nf[k]; end
    drive_rx(d, p, stop, 16);
    for (int k = 0; k < 2; k++) begin
      oc = model_outcome(k + 1, d, p, stop);
      check_counts(k, (oc == 0) ? 1 : 0, (oc == 1) ? 1 : 0, (oc == 2) ? 1 : 0,
                   bv[k], bp[k], bf[k], name);
      rd = (k == 0) ? rd_a : rd_b;
      checks++;
      if (last_rx[k] !== d || rd !== d) begin
        errors++;
        $display("FAIL %s dut%0d data: at pulse=%h now=%h, required %h",
                 name, k, last_rx[k], rd, d);
      end
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    enable = 1'b1;
    i_data = 8'hFF;
    repeat (3) tick();
    checks++;
    if (so_a !== 1'b1 || busy_a !== 1'b0 || rd_a !== 8'h00 || {dv_a, re_a, fe_a} !== 3'b000) begin
      errors++;
      $display("FAIL reset dut0: so=%b busy=%b rd=%h pulses=%b%b%b, required 1 0 00 000",
               so_a, busy_a, rd_a, dv_a, re_a, fe_a);
    end
    checks++;
    if (so_b !== 1'b1 || busy_b !== 1'b0 || rd_b !== 8'h00 || {dv_b, re_b, fe_b} !== 3'b000) begin
      errors++;
      $display("FAIL reset dut1: so=%b busy=%b rd=%h pulses=%b%b%b, required 1 0 00 000",
               so_b, busy_b, rd_b, dv_b, re_b, fe_b);
    end
    enable = 1'b0;
    reset  = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_tx_a5();
    tx_send(0, 8'hA5, "tx A5");
    repeat (3) tick();
  endtask

  task automatic test_loopback();
    int bv0, bp0, bf0, bv1, bp1, bf1;
    bv0 = nv[0]; bp0 = np[0]; bf0 = nf[0];
    bv1 = nv[1]; bp1 = np[1]; bf1 = nf[1];
    loopback = 1'b1;
    tx_send(0, 8'h3C, "loopback tx");
    repeat (20) tick();
    loopback = 1'b0;
    check_counts(0, 1, 0, 0, bv0, bp0, bf0, "loopback");
    check_counts(1, 1, 0, 0, bv1, bp1, bf1, "loopback");
    checks++;
    if (rd_a !== 8'h3C) begin
      errors++;
      $display("FAIL loopback data: received_data=%h, required 3c", rd_a);
    end
  endtask

  task automatic test_odd_parity();
    tx_send(1, 8'h01, "odd tx 01");
    repeat (2) tick();
    rx_frame_check(8'h01, 1'b1, 1'b1, "odd parity flipped");
  endtask

  task automatic test_framing();
    rx_frame_check(8'h96, 1'b0, 1'b0, "stop low");
    rx_frame_check(8'h55, 1'b0, 1'b1, "after framing 55");
  endtask

  task automatic test_glitch();
    int bv[2], bp[2], bf[2];
    for (int k = 0; k < 2; k++) begin bv[k] = nv[k]; bp[k] = np[k]; bf[k] = nf[k]; end
    rx_drive = 1'b0;
    repeat (2) tick();
    rx_drive = 1'b1;
    repeat (4 * CPB) tick();
    check_counts(0, 0, 0, 0, bv[0], bp[0], bf[0], "glitch");
    check_counts(1, 0, 0, 0, bv[1], bp[1], bf[1], "glitch");
    rx_frame_check(8'hE7, 1'b0, 1'b1, "after glitch");
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2;
    int bv0, bp0, bf0;
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    i_data = d1;
    enable = 1'b1;
    tick();
    i_data = d2;
    check_tx_frame(0, d1, "b2b first");
    tick();
    enable = 1'b0;
    check_tx_frame(0, d2, "b2b second");
    // Rx: second start bit follows the first stop bit with no idle gap.
    bv0 = nv[0]; bp0 = np[0]; bf0 = nf[0];
    drive_rx(d1, ^d1, 1'b1, 0);
    drive_rx(d2, ^d2, 1'b1, 16);
    check_counts(0, 2, 0, 0, bv0, bp0, bf0, "rx b2b");
    checks++;
    if (rd_a !== d2) begin
      errors++;
      $display("FAIL rx b2b data: received_data=%h, required %h", rd_a, d2);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic p, stop;
    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom);
      tx_send(n % 2, d, "random tx");
      repeat ($urandom_range(0, 3)) tick();
    end
    for (int n = 0; n < 16; n++) begin
      d    = 8'($urandom);
      p    = (^d) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      rx_frame_check(d, p, stop, "random rx");
    end
  endtask

  task automatic test_reset_midframe();
    int bv0, bp0, bf0;
    i_data = 8'hC3;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (30) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (so_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL midframe reset: serial_out=%b o_busy=%b, required 1/0", so_a, busy_a);
    end
    reset = 1'b1;
    tick();
    tx_send(0, 8'h5A, "after reset tx");
    // Abort an Rx frame part way through.
    bv0 = nv[0]; bp0 = np[0]; bf0 = nf[0];
    rx_drive = 1'b0;
    repeat (3 * CPB) tick();
    rx_drive = 1'b1;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (12 * CPB) tick();
    check_counts(0, 0, 0, 0, bv0, bp0, bf0, "rx midframe reset");
    checks++;
    if (rd_a !== 8'h00) begin
      errors++;
      $display("FAIL rx midframe reset data: received_data=%h, required 00", rd_a);
    end
    rx_frame_check(8'h81, 1'b0, 1'b1, "rx after reset");
  endtask

  initial begin
    test_reset();
    test_tx_a5();
    test_loopback();
    test_odd_parity();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
